// File: rtl/decoder_scan_pkg.sv
// decoder_scan_pkg: FSM state encoding shared by the decoder_scan files
package decoder_scan_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, SCAN = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/decoder_scan_bin2onehot.sv
// bin2onehot: combinational binary to one-hot decoder with enable
module bin2onehot #(
   parameter int SEL_W = 5
) (
   input  logic [SEL_W-1:0]    i_in,
   input  logic                i_en,
   output logic [2**SEL_W-1:0] o_out
);
   localparam int NUM_OUT = 2**SEL_W;
   assign o_out = i_en ? (NUM_OUT'(1) << i_in) : '0;
endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with scan sequencer; macro DECODER_SCAN_IDX_EN adds o_idx
module decoder_scan
   import decoder_scan_pkg::*;
#(
   parameter int SEL_W    = 5,
   parameter int SCAN_MAX = 2**SEL_W - 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic [SEL_W-1:0]   i_sel,
   input  logic               i_scan_start,
   input  logic               i_scan_ready,
   input  logic               i_scan_abort,
   output logic [2**SEL_W-1:0] o_out,
   output logic               o_valid,
   output logic               o_scan_busy,
   output logic               o_scan_last,
   output logic               o_scan_done
`ifdef DECODER_SCAN_IDX_EN
   ,output logic [SEL_W-1:0]  o_idx
`endif
);
   localparam int NUM_OUT = 2**SEL_W;
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(SCAN_MAX);
   state_t             r_state;
   logic [SEL_W-1:0]   r_idx;
   logic [NUM_OUT-1:0] r_out;
   logic               r_valid, r_busy, r_last, r_done;
   logic               w_start, w_adv, w_load, w_dec_en;
   logic [SEL_W-1:0]   w_idx_inc, w_dec_sel;
   logic [NUM_OUT-1:0] w_dec;
   assign w_idx_inc = r_idx + SEL_W'(1);
   assign w_start   = (r_state == IDLE) && i_scan_start && !i_scan_abort;
   assign w_adv     = (r_state == SCAN) && i_scan_ready && !i_scan_abort && (r_idx != LAST_IDX);
   // outputs reload everywhere except a stalled scan beat
   assign w_load    = (r_state != SCAN) || i_scan_abort || i_scan_ready;
   // the single decoder serves the scan index and the direct select
   assign w_dec_sel = (r_state == SCAN) ? w_idx_inc : (w_start ? '0 : i_sel);
   assign w_dec_en  = w_start || w_adv || ((r_state == IDLE) && i_en);
   bin2onehot #(.SEL_W(SEL_W)) u_dec (
      .i_in  (w_dec_sel),
      .i_en  (w_dec_en),
      .o_out (w_dec)
   );
   // scan FSM, index counter and registered outputs
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         if (w_load) begin
            r_out   <= w_dec;
            r_valid <= w_dec_en;
         end
         case (r_state)
            IDLE: if (w_start) begin
               r_state <= SCAN;
               r_idx   <= '0;
               r_busy  <= 1'b1;
               r_last  <= (LAST_IDX == '0);
            end
            SCAN: if (i_scan_abort || (i_scan_ready && r_idx == LAST_IDX)) begin
               r_state <= i_scan_abort ? IDLE : DONE;
               r_done  <= !i_scan_abort;
               r_idx   <= '0;
               r_busy  <= 1'b0;
               r_last  <= 1'b0;
            end else if (i_scan_ready) begin
               r_idx  <= w_idx_inc;
               r_last <= (w_idx_inc == LAST_IDX);
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
`ifdef DECODER_SCAN_IDX_EN
   logic [SEL_W-1:0] r_bin;
   // binary index of the bit loaded into o_out, zero when nothing is valid
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_bin <= '0;
      else if (w_load) r_bin <= w_dec_en ? w_dec_sel : '0;
   end
   assign o_idx = r_bin;
`endif
   assign o_out       = r_out;
   assign o_valid     = r_valid;
   assign o_scan_busy = r_busy;
   assign o_scan_last = r_last;
   assign o_scan_done = r_done;
endmodule
